// File: rtl/bf_io_pkg.sv
// Shared types for the Boolfuck output path: TX FSM states, byte width, frame length.
// BF_OUT_PARITY_EN selects 8E1 (11-bit frames) instead of 8N1 (10-bit frames).
package bf_io_pkg;

    localparam int BF_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int frame_bits();
`ifdef BF_OUT_PARITY_EN
        return 11;
`else
        return 10;
`endif
    endfunction

endpackage

// File: rtl/bf_out_uart_if.sv
// Output-bit handshake between the interpreter (master) and the UART packer (slave).
interface bf_out_uart_if;

    logic out_valid;
    logic out_bit;
    logic out_ready;
    logic flush;

    modport master (
        output out_valid,
        output out_bit,
        output flush,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_bit,
        input  flush,
        output out_ready
    );

endinterface

// File: rtl/bf_uart_tx_shifter.sv
// UART frame serialiser: START, 8 data bits LSB first, optional even PARITY (BF_OUT_PARITY_EN), STOP.
// Latency: i_load in IDLE puts the start bit on o_txd the following cycle; o_txd is registered.
// Backpressure: i_load is only honoured in IDLE; the caller holds data until o_busy is low.
module bf_uart_tx_shifter
    import bf_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [BF_BYTE_W-1:0] i_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_txd
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic [BAUD_W-1:0]    r_baud;
    logic [2:0]           r_bitcnt;
    logic [BF_BYTE_W-1:0] r_shift;
    logic                 r_par;
    logic                 r_txd;
    logic                 w_last;
    logic                 w_txd_nxt;

    assign w_last = (r_baud == BAUD_LAST);
    assign o_txd  = r_txd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:   if (i_load) w_state_nxt = START;
            START:  if (w_last) w_state_nxt = DATA;
            DATA: begin
                if (w_last && (r_bitcnt == 3'd7)) begin
`ifdef BF_OUT_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
            PARITY: if (w_last) w_state_nxt = STOP;
            STOP:   if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // txd level is chosen from the state being entered so the pin changes on the same edge as the FSM.
    always_comb begin
        w_txd_nxt = r_txd;
        o_busy    = (r_state != IDLE);
        o_done    = (r_state == STOP) && w_last;
        unique case (w_state_nxt)
            IDLE:   w_txd_nxt = 1'b1;
            START:  w_txd_nxt = 1'b0;
            DATA: begin
                if (r_state != DATA) begin
                    w_txd_nxt = r_shift[0];
                end else if (w_last) begin
                    w_txd_nxt = r_shift[1];
                end
            end
            PARITY: w_txd_nxt = r_par;
            STOP:   w_txd_nxt = 1'b1;
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_txd    <= 1'b1;
        end else begin
            r_txd <= w_txd_nxt;
            if ((r_state == IDLE) || w_last) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state != w_state_nxt) begin
                r_bitcnt <= '0;
            end else if ((r_state == DATA) && w_last) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if ((r_state == IDLE) && i_load) begin
                r_shift <= i_data;
                r_par   <= ^i_data;
            end else if ((r_state == DATA) && w_last) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

// File: rtl/bf_out_uart.sv
// Packs interpreter output bits LSB-first into bytes and sends each byte as a UART frame on txd.
// Latency: 8th bit accepted at cycle N -> start bit on txd from cycle N+2; parity via BF_OUT_PARITY_EN.
// Backpressure: out_ready drops while a completed byte waits for the transmitter to go idle.
module bf_out_uart
    import bf_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bf_out_uart_if.slave     out_if,
    output logic             txd,
    output logic             tx_busy,
    output logic [2:0]       pending,
    output logic [CNT_W-1:0] bytes_sent
);

    logic [BF_BYTE_W-1:0] r_acc;
    logic [2:0]           r_idx;
    logic                 r_full;
    logic [CNT_W-1:0]     r_bytes_sent;

    logic                 w_accept;
    logic [2:0]           w_idx_acc;
    logic                 w_full_set;
    logic                 w_load;
    logic                 w_tx_busy;
    logic                 w_tx_done;

    assign w_accept  = out_if.out_valid & ~r_full;
    assign w_idx_acc = w_accept ? (r_idx + 3'd1) : r_idx;
    // A same-cycle flush looks at the index after the accept; an accept of bit 7 wraps it to 0.
    assign w_full_set = (w_accept && (r_idx == 3'd7)) ||
                        (out_if.flush && !r_full && (w_idx_acc != 3'd0));
    assign w_load    = r_full & ~w_tx_busy;

    assign out_if.out_ready = ~r_full;
    assign pending          = r_full ? 3'd0 : r_idx;
    assign tx_busy          = w_tx_busy;
    assign bytes_sent       = r_bytes_sent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_full <= 1'b0;
        end else if (w_load) begin
            r_acc  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc[r_idx] <= out_if.out_bit;
            end
            if (w_full_set) begin
                r_full <= 1'b1;
                r_idx  <= '0;
            end else begin
                r_idx  <= w_idx_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_sent <= '0;
        end else if (w_tx_done) begin
            r_bytes_sent <= r_bytes_sent + 1'b1;
        end
    end

    bf_uart_tx_shifter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_data (r_acc),
        .o_busy (w_tx_busy),
        .o_done (w_tx_done),
        .o_txd  (txd)
    );

endmodule

// File: tb/tb_bf_out_uart.sv
// Bench for bf_out_uart with CLKS_PER_BIT=4; frame checks follow BF_OUT_PARITY_EN.
module tb_bf_out_uart;
    import bf_io_pkg::*;

    localparam int CPB = 4;
    localparam int FB  = frame_bits();
    localparam int FC  = FB * CPB;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        txd;
    logic        tx_busy;
    logic [2:0]  pending;
    logic [15:0] bytes_sent;

    bf_out_uart_if bus ();

    bf_out_uart #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_if     (bus),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .pending    (pending),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_sent = 0;
    int          last_start = 0;
    bit          saw_stall = 1'b0;
    logic [43:0] mon_q[$];
    int          mon_start_q[$];

    // Capture every frame as one txd sample per cycle, starting at the first low cycle.
    initial begin : monitor
        logic [43:0] s;
        bit          abort;
        int          st;
        forever begin
            @(negedge clk);
            if (rst_n && (txd == 1'b0)) begin
                st    = cyc;
                s     = '0;
                abort = 1'b0;
                for (int k = 1; k < FC; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    s[k] = txd;
                end
                if (!abort) begin
                    mon_q.push_back(s);
                    mon_start_q.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [43:0] expand(input logic [7:0] d);
        logic [10:0] lv;
        logic [43:0] r;
        lv    = '1;
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = d[i];
`ifdef BF_OUT_PARITY_EN
        lv[9]  = ^d;
        lv[10] = 1'b1;
`else
        lv[9]  = 1'b1;
`endif
        r = '0;
        for (int k = 0; k < FC; k++) r[k] = lv[k/CPB];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input logic with_flush);
        int n;
        bus.out_valid = 1'b1;
        bus.out_bit   = b;
        bus.flush     = with_flush;
        n = 0;
        while (!bus.out_ready && n < 400) begin
            saw_stall = 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: out_ready 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        bus.out_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], 1'b0);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] exp_b);
        int n;
        n = 0;
        while (mon_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (mon_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no frame within %0d cycles, required byte 0x%02h", name, n, exp_b);
        end else begin
            last_start = mon_start_q.pop_front();
            check(name, 64'(mon_q.pop_front()), 64'(expand(exp_b)));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_busy || !bus.out_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: tx_busy=%0b out_ready=%0b, required 0/1", tx_busy, bus.out_ready);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         use_flush;
        logic [7:0] exp_byte;
    } vec_t;

    localparam int NV = 7;
    vec_t vt[NV];

    initial begin : stim
        int s1;
        vt[0] = '{8'h41, 8, 1'b0, 8'h41};
        vt[1] = '{8'h07, 3, 1'b1, 8'h07};
        vt[2] = '{8'hA5, 8, 1'b0, 8'hA5};
        vt[3] = '{8'h35, 6, 1'b1, 8'h35};
        vt[4] = '{8'hFF, 1, 1'b1, 8'h01};
        vt[5] = '{8'h00, 8, 1'b0, 8'h00};
        vt[6] = '{8'h43, 8, 1'b0, 8'h43};

        bus.out_valid = 1'b0;
        bus.out_bit   = 1'b0;
        bus.flush     = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check("rst_txd",        64'(txd), 64'd1);
        check("rst_tx_busy",    64'(tx_busy), 64'd0);
        check("rst_out_ready",  64'(bus.out_ready), 64'd1);
        check("rst_pending",    64'(pending), 64'd0);
        check("rst_bytes_sent", 64'(bytes_sent), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            send_byte(vt[i].data, vt[i].nbits);
            if (vt[i].use_flush) begin
                check($sformatf("vec%0d_pending_pre", i), 64'(pending), 64'(vt[i].nbits));
                pulse_flush();
            end
            check($sformatf("vec%0d_pending_post", i), 64'(pending), 64'd0);
            expect_frame($sformatf("vec%0d_frame", i), vt[i].exp_byte);
            wait_idle();
            exp_sent++;
            check($sformatf("vec%0d_bytes_sent", i), 64'(bytes_sent), 64'(exp_sent));
        end

        // Flush with nothing pending must not start a frame.
        pulse_flush();
        repeat (FC + 10) @(negedge clk);
        check("empty_flush_frames", 64'(mon_q.size()), 64'd0);
        check("empty_flush_busy",   64'(tx_busy), 64'd0);
        check("empty_flush_sent",   64'(bytes_sent), 64'(exp_sent));

        // Two bytes with out_valid held: stall, then frames one cycle apart.
        saw_stall = 1'b0;
        send_byte(8'h3C, 8);
        send_byte(8'hC3, 8);
        check("b2b_stall_seen", 64'(saw_stall), 64'd1);
        expect_frame("b2b_frame0", 8'h3C);
        s1 = last_start;
        expect_frame("b2b_frame1", 8'hC3);
        check("b2b_start_gap", 64'(last_start - s1), 64'(FC + 1));
        wait_idle();
        exp_sent += 2;
        check("b2b_bytes_sent", 64'(bytes_sent), 64'(exp_sent));

        // 7th bit and flush together: all seven bits go out, top bit padded.
        send_byte(8'h55, 6);
        drive_bit(1'b1, 1'b1);
        check("flush7_pending", 64'(pending), 64'd0);
        expect_frame("flush7_frame", 8'h55);
        wait_idle();
        check("flush7_no_extra", 64'(mon_q.size()), 64'd0);
        exp_sent++;
        check("flush7_bytes_sent", 64'(bytes_sent), 64'(exp_sent));

        // 8th bit and flush together: exactly one frame.
        send_byte(8'hB2, 7);
        drive_bit(1'b1, 1'b1);
        expect_frame("flush8_frame", 8'hB2);
        repeat (FC + 10) @(negedge clk);
        check("flush8_no_extra", 64'(mon_q.size()), 64'd0);
        check("flush8_pending", 64'(pending), 64'd0);
        exp_sent++;
        check("flush8_bytes_sent", 64'(bytes_sent), 64'(exp_sent));

        // Reset during data bit 3 aborts the frame immediately.
        send_byte(8'hF0, 8);
        s1 = 0;
        while (txd !== 1'b0 && s1 < 400) begin
            @(negedge clk);
            s1++;
        end
        check("mid_start_seen", 64'(txd), 64'd0);
        repeat (CPB + 3 * CPB + 1) @(negedge clk);
        check("mid_txd_bit3", 64'(txd), 64'd0);
        check("mid_busy", 64'(tx_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd",       64'(txd), 64'd1);
        check("mid_rst_busy",      64'(tx_busy), 64'd0);
        check("mid_rst_out_ready", 64'(bus.out_ready), 64'd1);
        check("mid_rst_pending",   64'(pending), 64'd0);
        check("mid_rst_sent",      64'(bytes_sent), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_sent = 0;
        @(negedge clk);
        send_byte(8'h5A, 8);
        expect_frame("post_rst_frame", 8'h5A);
        wait_idle();
        exp_sent++;
        check("post_rst_bytes_sent", 64'(bytes_sent), 64'(exp_sent));
        check("post_rst_no_extra", 64'(mon_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
